// File: rtl/result_uart_tx_if.sv
// Bundle between the program-check stage and the result UART: run flag and
// result byte in, serial line and status out.
interface result_uart_tx_if;
    logic [7:0] returnValue;
    logic       programIsRunning;
    logic       txd;
    logic       busy;
    logic       sent;

    modport slave (
        input  returnValue,
        input  programIsRunning,
        output txd,
        output busy,
        output sent
    );

    modport master (
        output returnValue,
        output programIsRunning,
        input  txd,
        input  busy,
        input  sent
    );
endinterface

// File: rtl/result_uart_tx.sv
// Sends the captured result byte then a terminator as two back-to-back 8N1 frames
// when programIsRunning falls; latency 1 cycle flag-to-line, no backpressure (retriggers while busy are dropped).
module result_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [7:0]  TERMINATOR   = 8'h0A
) (
    input  logic            clk,
    input  logic            rst_n,
    result_uart_tx_if.slave bus
);
    localparam int unsigned   CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    term_q, term_d;
    logic          second_q, second_d;
    logic          txd_q, txd_d;
    logic          busy_q, busy_d;
    logic          sent_q, sent_d;
    logic          run_q;
    logic          trig;
    logic          bit_end;

    assign trig    = run_q & ~bus.programIsRunning;
    assign bit_end = (cnt_q == CNT_MAX);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        term_d   = term_q;
        second_d = second_q;
        txd_d    = txd_q;
        busy_d   = busy_q;
        sent_d   = 1'b0;

        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d  = START;
                    shift_d  = bus.returnValue;
                    term_d   = TERMINATOR;
                    second_d = 1'b0;
                    cnt_d    = '0;
                    txd_d    = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                    txd_d   = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        txd_d   = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (second_q) begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                        busy_d  = 1'b0;
                        sent_d  = 1'b1;
                    end else begin
                        // Terminator frame follows with no idle gap on the line.
                        state_d  = START;
                        shift_d  = term_q;
                        second_d = 1'b1;
                        txd_d    = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            shift_q  <= 8'h00;
            term_q   <= 8'h00;
            second_q <= 1'b0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            sent_q   <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            term_q   <= term_d;
            second_q <= second_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            sent_q   <= sent_d;
            run_q    <= bus.programIsRunning;
        end
    end

    assign bus.txd  = txd_q;
    assign bus.busy = busy_q;
    assign bus.sent = sent_q;
endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx: expected line bits are queued when a message
// is triggered and compared cycle by cycle as the DUT shifts them out.
module tb_result_uart_tx;
    localparam int         CPB  = 4;
    localparam logic [7:0] TERM = 8'h0A;

    logic clk;
    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;
    logic exp_q[$];

    result_uart_tx_if bus();

    result_uart_tx #(.CLKS_PER_BIT(CPB), .TERMINATOR(TERM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_txd"},  {7'd0, bus.txd},  8'd1);
        chk({tag, "_busy"}, {7'd0, bus.busy}, 8'd0);
        chk({tag, "_sent"}, {7'd0, bus.sent}, 8'd0);
    endtask

    task automatic push_frame(input logic [7:0] b);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        exp_q.push_back(1'b1);
    endtask

    // Drops the flag (which must have been high for at least one edge) and follows
    // the message to cycle 81 after the trigger edge. mode: 0 plain, 1 change
    // returnValue mid-frame, 2 retrigger while busy, 3 reset at cycle 17.
    task automatic run_msg(input logic [7:0] rv, input int mode);
        logic exp_bit;
        bus.returnValue      = rv;
        bus.programIsRunning = 1'b0;
        push_frame(rv);
        push_frame(TERM);
        chk("pre_edge_txd", {7'd0, bus.txd}, 8'd1);
        tick();
        for (int c = 0; c <= 81; c++) begin
            if (mode == 1 && c == 10) bus.returnValue = 8'hFF;
            if (mode == 2 && c == 30) bus.programIsRunning = 1'b1;
            if (mode == 2 && c == 31) bus.programIsRunning = 1'b0;
            if (mode == 3 && c == 17) begin
                rst_n = 1'b0;
                #1;
                chk_idle("async_rst");
                exp_q.delete();
                return;
            end
            if (c < 80) begin
                exp_bit = (exp_q.size() > 0) ? exp_q[0] : 1'bx;
                chk("txd_bit", {7'd0, bus.txd}, {7'd0, exp_bit});
                chk("busy_msg", {7'd0, bus.busy}, 8'd1);
                chk("sent_early", {7'd0, bus.sent}, 8'd0);
                if (c % CPB == CPB - 1) void'(exp_q.pop_front());
            end else begin
                chk("end_txd", {7'd0, bus.txd}, 8'd1);
                chk("end_busy", {7'd0, bus.busy}, 8'd0);
                chk("end_sent", {7'd0, bus.sent}, {7'd0, (c == 80)});
            end
            if (c < 81) tick();
        end
    endtask

    initial begin
        rst_n                = 1'b0;
        bus.returnValue      = 8'h00;
        bus.programIsRunning = 1'b1;
        #12;
        chk_idle("reset");

        // Flag high out of reset must never trigger.
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 500; i++) begin
            tick();
            chk_idle("held_high");
        end

        run_msg(8'h3E, 0);

        // Back-to-back: second trigger edge lands 85 cycles after the first.
        tick();
        tick();
        bus.programIsRunning = 1'b1;
        tick();
        run_msg(8'h3E, 0);

        bus.programIsRunning = 1'b1;
        tick();
        run_msg(8'h05, 1);

        bus.programIsRunning = 1'b1;
        tick();
        run_msg(8'h3E, 2);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_idle("after_retrig");
        end

        bus.programIsRunning = 1'b1;
        tick();
        run_msg(8'hA5, 3);
        tick();
        chk_idle("in_reset");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk_idle("post_reset_low");
        end

        bus.programIsRunning = 1'b1;
        tick();
        run_msg(8'h81, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
